// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// XLEN is fixed here so the fetch entry struct and every port agree on width.
package fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP          = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Word alignment test for instruction addresses.
    function automatic logic is_aligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small queue of {pc, instr} entries between fetch and decode.
// DEPTH must be a power of two so the pointers wrap naturally.
// Flush wins over push and pop; head reads as zero while empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     wr_data,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             empty;
    logic             do_push;
    logic             do_pop;
    logic             clear;

    assign clear   = rst | flush;
    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A full queue can still accept when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; reset/flush empty the queue.
    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; left unreset because head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, samples the combinational
// instruction memory, queues {pc, instr} for decode and handles redirects.
// Optional feature macro: FETCH_MISALIGN_EN -- a misaligned redirect target
// raises a sticky misalign_fault and halts fetching until rst or an aligned
// redirect. Without it the low two target bits are ignored.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr,
    output logic            misalign_fault
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [XLEN-1:0]  fetch_pc;
    logic [XLEN-1:0]  redirect_target;
    logic             halted;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic [CNT_W-1:0] fifo_count;
    fetch_entry_t     wr_entry;
    fetch_entry_t     head_entry;

    assign imem_addr = fetch_pc;
    assign out_valid = (fifo_count != '0);
    assign out_pc    = head_entry.pc;
    assign out_instr = head_entry.instr;

    assign pop  = out_valid & out_ready;
    // Redirect suppresses the push; the queue is flushed that same cycle.
    assign push = ~redirect_valid & ~halted & (~fifo_full | pop);

    assign wr_entry.pc    = fetch_pc;
    assign wr_entry.instr = imem_rdata;

`ifdef FETCH_MISALIGN_EN
    assign redirect_target = redirect_pc;

    // Sticky fault: every redirect re-evaluates it, so only an aligned
    // redirect (or reset) can clear it.
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_fault <= 1'b0;
            halted         <= 1'b0;
        end else if (redirect_valid) begin
            misalign_fault <= ~is_aligned(redirect_pc);
            halted         <= ~is_aligned(redirect_pc);
        end
    end
`else
    logic unused_redirect_lsbs;

    assign redirect_target      = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign misalign_fault       = 1'b0;
    assign halted               = 1'b0;
`endif

    // Program counter: reset, then redirect, then sequential advance on push.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_target;
        end else if (push) begin
            fetch_pc <= fetch_pc + PC_STEP;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .flush   (redirect_valid),
        .wr_data (wr_entry),
        .head    (head_entry),
        .count   (fifo_count),
        .full    (fifo_full)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run, all
// compared against a queue-based model of the fetch stage.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        misalign_fault;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mq [$];
    logic [31:0] m_pc;
    logic        m_fault;

    fetch_unit #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .misalign_fault (misalign_fault)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    assign imem_rdata = instr_of(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of one clock edge: queue of fetched pcs, next fetch address, fault.
    task automatic model_update();
        if (rst) begin
            mq.delete();
            m_pc    = RESET_PC;
            m_fault = 1'b0;
        end else if (redirect_valid) begin
            mq.delete();
`ifdef FETCH_MISALIGN_EN
            m_pc    = redirect_pc;
            m_fault = (redirect_pc[1:0] != 2'b00);
`else
            m_pc    = redirect_pc & ~32'h3;
`endif
        end else begin
            if (out_ready && mq.size() != 0) void'(mq.pop_front());
            if (!m_fault && mq.size() < DEPTH) begin
                mq.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    // Advance one cycle; return at the negedge with outputs settled.
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        step();
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid got=%0b exp=0", out_valid);
        end
        checks++;
        if (imem_addr !== RESET_PC) begin
            failures++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, RESET_PC);
        end
        checks++;
        if (out_pc !== 32'h0 || out_instr !== 32'h0) begin
            failures++; $display("FAIL reset_out got=%h/%h exp=0/0", out_pc, out_instr);
        end
        checks++;
        if (misalign_fault !== 1'b0) begin
            failures++; $display("FAIL reset_fault got=%0b exp=0", misalign_fault);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'(4 * i) || out_instr !== instr_of(32'(4 * i))) begin
                failures++;
                $display("FAIL reset_stream[%0d] got v=%0b pc=%h instr=%h exp pc=%h instr=%h",
                         i, out_valid, out_pc, out_instr, 32'(4 * i), instr_of(32'(4 * i)));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc;
        rst = 1'b1; out_ready = 1'b0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i >= 1) begin
                checks++;
                if (imem_addr !== 32'h8 || out_valid !== 1'b1 || out_pc !== 32'h0) begin
                    failures++;
                    $display("FAIL bp_stall[%0d] got addr=%h v=%0b pc=%h exp addr=8 v=1 pc=0",
                             i, imem_addr, out_valid, out_pc);
                end
            end
        end
        out_ready = 1'b1;
        exp_pc = 32'h0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instr !== instr_of(exp_pc)) begin
                failures++;
                $display("FAIL bp_release[%0d] got v=%0b pc=%h exp pc=%h", i, out_valid, out_pc, exp_pc);
            end
            exp_pc = exp_pc + 32'd4;
            step();
        end
    endtask

    task automatic test_redirect_full();
        out_ready = 1'b0;
        step(); step(); step();
        redirect_valid = 1'b1; redirect_pc = 32'h100; out_ready = 1'b1;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || imem_addr !== 32'h100) begin
            failures++;
            $display("FAIL redir_flush got v=%0b addr=%h exp v=0 addr=100", out_valid, imem_addr);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'h100 + 32'(4 * i)) begin
                failures++;
                $display("FAIL redir_target[%0d] got v=%0b pc=%h exp pc=%h",
                         i, out_valid, out_pc, 32'h100 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        step();
        redirect_pc = 32'h400;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || imem_addr !== 32'h400) begin
            failures++;
            $display("FAIL b2b_flush got v=%0b addr=%h exp v=0 addr=400", out_valid, imem_addr);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h400) begin
            failures++;
            $display("FAIL b2b_target got v=%0b pc=%h exp pc=400", out_valid, out_pc);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_seq [3];
        exp_seq[0] = 32'hFFFF_FFF8;
        exp_seq[1] = 32'hFFFF_FFFC;
        exp_seq[2] = 32'h0000_0000;
        out_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== exp_seq[i] || misalign_fault !== 1'b0) begin
                failures++;
                $display("FAIL wrap[%0d] got v=%0b pc=%h fault=%0b exp pc=%h fault=0",
                         i, out_valid, out_pc, misalign_fault, exp_seq[i]);
            end
        end
    endtask

    task automatic test_rst_mid();
        out_ready = 1'b0;
        step(); step(); step();
        rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h500;
        step();
        checks++;
        if (out_valid !== 1'b0 || imem_addr !== RESET_PC || out_pc !== 32'h0) begin
            failures++;
            $display("FAIL rst_mid got v=%0b addr=%h pc=%h exp v=0 addr=%h pc=0",
                     out_valid, imem_addr, out_pc, RESET_PC);
        end
        rst = 1'b0; redirect_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== RESET_PC) begin
            failures++;
            $display("FAIL rst_mid_restart got v=%0b pc=%h exp pc=%h", out_valid, out_pc, RESET_PC);
        end
    endtask

`ifdef FETCH_MISALIGN_EN
    task automatic test_misalign();
        out_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (misalign_fault !== 1'b1 || out_valid !== 1'b0 || imem_addr !== 32'h102) begin
                failures++;
                $display("FAIL misalign_halt[%0d] got fault=%0b v=%0b addr=%h exp fault=1 v=0 addr=102",
                         i, misalign_fault, out_valid, imem_addr);
            end
            step();
        end
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (misalign_fault !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL misalign_clear got fault=%0b v=%0b exp 0/0", misalign_fault, out_valid);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h200) begin
            failures++;
            $display("FAIL misalign_resume got v=%0b pc=%h exp pc=200", out_valid, out_pc);
        end
    endtask
`else
    task automatic test_misalign();
        out_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (misalign_fault !== 1'b0 || imem_addr !== 32'h100) begin
            failures++;
            $display("FAIL misalign_ignored got fault=%0b addr=%h exp fault=0 addr=100",
                     misalign_fault, imem_addr);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h100) begin
            failures++;
            $display("FAIL misalign_ignored_out got v=%0b pc=%h exp pc=100", out_valid, out_pc);
        end
    endtask
`endif

    task automatic test_random();
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        int          bad;
        bad = 0;
        rst = 1'b1; redirect_valid = 1'b0; out_ready = 1'b0;
        step();
        for (int i = 0; i < 400; i++) begin
            rst            = ($urandom_range(63) == 0);
            redirect_valid = ($urandom_range(11) == 0);
            redirect_pc    = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(15))
                                                      : $urandom;
            if ($urandom_range(3) != 0) redirect_pc[1:0] = 2'b00;
            out_ready      = ($urandom_range(9) < 7);
            step();
            exp_valid = (mq.size() != 0);
            exp_pc    = exp_valid ? mq[0] : 32'h0;
            exp_instr = exp_valid ? instr_of(mq[0]) : 32'h0;
            checks++;
            if (out_valid !== exp_valid || out_pc !== exp_pc || out_instr !== exp_instr ||
                imem_addr !== m_pc || misalign_fault !== m_fault) begin
                failures++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random[%0d] got v=%0b pc=%h instr=%h addr=%h f=%0b exp v=%0b pc=%h instr=%h addr=%h f=%0b",
                             i, out_valid, out_pc, out_instr, imem_addr, misalign_fault,
                             exp_valid, exp_pc, exp_instr, m_pc, m_fault);
            end
        end
        rst = 1'b0; redirect_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        out_ready = 1'b0;
        m_pc = RESET_PC;
        m_fault = 1'b0;
        test_reset();
        test_backpressure();
        test_redirect_full();
        test_back_to_back();
        test_wrap();
        test_rst_mid();
        test_misalign();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
